// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue -- prefetching instruction-fetch queue for the Fetch stage.
//
// Issues sequential fetch requests to the instruction SRAM port, accepts
// in-order responses of any latency and buffers {pc, instr} pairs for the
// datapath. A redirect discards everything buffered and in flight and
// restarts fetching at the new PC.
//
// Parameters:
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   redirect          discard contents, restart at redirect_pc
//   redirect_pc[31:0] restart address (word aligned)
//   stallF            consumer not accepting this cycle
//   imem_req          fetch request valid
//   imem_addr[31:0]   fetch address
//   imem_gnt          request accepted when imem_req & imem_gnt
//   imem_rvalid       response valid (strictly in request order)
//   imem_rdata[31:0]  response instruction word
//   inst_valid        head entry valid
//   instrF[31:0]      head instruction (0 when empty)
//   pcF[31:0]         head PC (0 when empty)
//   dbg_state         FSM state (0 = RUN, 1 = FLUSH)
//
// Handshakes: a fetch transfers when imem_req & imem_gnt; imem_req may be
// withdrawn freely because credits are recomputed every cycle. An
// instruction leaves the queue when inst_valid & ~stallF & ~redirect.
//
// Build option: define IFQ_BYPASS_EN to forward a response straight to
// instrF/pcF in its arrival cycle while the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stallF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic        dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic [CW:0]   credit_sum;
  logic          grant, buf_valid, byp_hit, deq, deq_buf, byp_take, enq;
  logic [31:0]   resp_pc;

  // Every outstanding request is sequential from the oldest one, so the PC
  // of the response now arriving is fetch_pc minus 4 per request in flight.
  assign resp_pc    = fetch_pc_q - (32'(inflight_q) << 2);

  // Credits: buffered plus in-flight never exceeds DEPTH, so a response
  // always finds a free slot.
  assign credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req   = (state_q == RUN) & ~redirect & ~rst &
                      (credit_sum < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc_q;
  assign grant      = imem_req & imem_gnt;
  assign buf_valid  = (count_q != '0);

`ifdef IFQ_BYPASS_EN
  // Redirect-cycle responses are stale, so they are never forwarded.
  assign byp_hit = ~buf_valid & (state_q == RUN) & imem_rvalid & ~redirect;
`else
  assign byp_hit = 1'b0;
`endif

  assign inst_valid = buf_valid | byp_hit;
  assign instrF     = buf_valid ? instr_mem_q[rd_ptr_q] :
                      (byp_hit ? imem_rdata : 32'h0);
  assign pcF        = buf_valid ? pc_mem_q[rd_ptr_q] :
                      (byp_hit ? resp_pc : 32'h0);

  assign deq        = inst_valid & ~stallF & ~redirect;
  assign deq_buf    = deq & buf_valid;
  // A forwarded response that is consumed immediately never occupies a slot.
  assign byp_take   = deq & byp_hit;
  assign enq        = imem_rvalid & (state_q == RUN) & ~redirect & ~byp_take;
  assign dbg_state  = state_q;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      // No request can be granted in a redirect cycle.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      inflight_d = inflight_q - CW'(imem_rvalid);
      state_d    = (inflight_d != '0) ? FLUSH : RUN;
    end else begin
      if (enq)     wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq_buf) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d    = count_q + CW'(enq) - CW'(deq_buf);
      inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid);
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (state_q == FLUSH && inflight_d == '0) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]    <= resp_pc;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // A response landing on a full queue means the credit rule was broken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && state_q == RUN && count_q == CW'(DEPTH)));
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue -- self-checking bench for inst_fetch_queue.
// A memory model answers granted requests after a fixed latency; every
// response that should survive is pushed to an expected queue and compared
// against the head presented on pcF/instrF.
module tb_inst_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        rst, redirect, stallF, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid, dbg_state;
  logic [31:0] imem_addr, instrF, pcF;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .stallF(stallF), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .instrF(instrF), .pcF(pcF), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  req_t        pending[$];
  logic [63:0] exp_q[$];
  vec_t        vecs[NV];

  int          cyc, lat, n_cmp, n_fail, n_drop, n_deq, n_grant;
  int          last_drop_cyc, first_req_cyc;
  bit          gnt_rand, cur_stale, seen_req, seen_deq;
  logic [31:0] cur_addr, first_req_addr, first_deq_pc;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h2402_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observe the current cycle away from the clock edge: scoreboard and
  // memory-model bookkeeping.
  task automatic obs();
    req_t r;
    @(negedge clk);
    if (rst) begin
      pending.delete();
      exp_q.delete();
    end else begin
      if (imem_rvalid) begin
        if (cur_stale || redirect) begin
          n_drop++;
          last_drop_cyc = cyc;
        end else begin
          exp_q.push_back({cur_addr, data_of(cur_addr)});
        end
      end
      if (inst_valid && !redirect) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_empty: valid with pc %h but nothing expected (cycle %0d)", pcF, cyc);
        end else begin
          check("sb_pc", pcF, exp_q[0][63:32]);
          check("sb_instr", instrF, exp_q[0][31:0]);
          if (!stallF) begin
            if (!seen_deq) begin
              seen_deq     = 1'b1;
              first_deq_pc = pcF;
            end
            void'(exp_q.pop_front());
            n_deq++;
          end
        end
      end
      if (imem_req && !seen_req) begin
        seen_req       = 1'b1;
        first_req_cyc  = cyc;
        first_req_addr = imem_addr;
      end
      if (imem_req && imem_gnt) begin
        r.addr  = imem_addr;
        r.due   = cyc + lat;
        r.stale = 1'b0;
        pending.push_back(r);
        n_grant++;
      end
      if (redirect) begin
        exp_q.delete();
        for (int i = 0; i < pending.size(); i++) pending[i].stale = 1'b1;
        seen_req = 1'b0;
        seen_deq = 1'b0;
      end
    end
  endtask

  // Advance to the next cycle and drive the memory side for it.
  task automatic adv();
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      r           = pending.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = data_of(r.addr);
      cur_addr    = r.addr;
      cur_stale   = r.stale;
    end
  endtask

  task automatic do_reset(input bit chk);
    rst      = 1'b1;
    redirect = 1'b0;
    stallF   = 1'b0;
    gnt_rand = 1'b0;
    obs();
    if (chk) begin
      check("rst_req", 32'(imem_req), 32'h0);
      check("rst_valid", 32'(inst_valid), 32'h0);
      check("rst_instr", instrF, 32'h0);
      check("rst_pc", pcF, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_state", 32'(dbg_state), 32'h0);
    end
    adv();
    obs();
    adv();
    rst      = 1'b0;
    cyc      = 0;
    n_drop   = 0;
    n_deq    = 0;
    n_grant  = 0;
    seen_req = 1'b1;
    seen_deq = 1'b1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; stallF = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    cyc = 0; lat = 1; n_cmp = 0; n_fail = 0; gnt_rand = 1'b0;
    cur_stale = 1'b0; cur_addr = 32'h0;

    // Sequential streaming with single-cycle memory: one request and one
    // instruction per cycle.
    for (int k = 0; k < NV; k++) begin
      vecs[k].stall     = 1'b0;
      vecs[k].exp_req   = 1'b1;
      vecs[k].exp_addr  = 32'(4 * k);
      vecs[k].exp_valid = (k >= 2 - BYP);
      vecs[k].exp_pc    = vecs[k].exp_valid ? 32'(4 * (k - 2 + BYP)) : 32'h0;
      vecs[k].exp_instr = vecs[k].exp_valid ? data_of(vecs[k].exp_pc) : 32'h0;
    end

    do_reset(1'b1);
    lat = 1;
    for (int k = 0; k < NV; k++) begin
      stallF = vecs[k].stall;
      obs();
      check("t1_req", 32'(imem_req), 32'(vecs[k].exp_req));
      check("t1_addr", imem_addr, vecs[k].exp_addr);
      check("t1_valid", 32'(inst_valid), 32'(vecs[k].exp_valid));
      check("t1_pc", pcF, vecs[k].exp_pc);
      check("t1_instr", instrF, vecs[k].exp_instr);
      adv();
    end

    // Ten stalled cycles fill the queue, then four in-order dequeues.
    do_reset(1'b0);
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      stallF = 1'b1;
      obs();
      if (i == 9) begin
        check("t2_req_dropped", 32'(imem_req), 32'h0);
        check("t2_full_valid", 32'(inst_valid), 32'h1);
        check("t2_head_pc", pcF, 32'h0);
      end
      adv();
    end
    check("t2_grants", 32'(n_grant), 32'd4);
    for (int i = 0; i < 4; i++) begin
      stallF = 1'b0;
      obs();
      check("t2_drain_valid", 32'(inst_valid), 32'h1);
      check("t2_drain_pc", pcF, 32'(4 * i));
      adv();
    end

    // Redirect with three requests in flight on a 3-cycle memory.
    do_reset(1'b0);
    lat = 3;
    for (int c = 0; c < 16; c++) begin
      redirect    = (c == 3);
      redirect_pc = 32'h100;
      obs();
      if (c == 4 || c == 5) begin
        check("t3_flush_state", 32'(dbg_state), 32'h1);
        check("t3_flush_noreq", 32'(imem_req), 32'h0);
        check("t3_valid_low", 32'(inst_valid), 32'h0);
      end
      adv();
    end
    redirect = 1'b0;
    check("t3_drops", 32'(n_drop), 32'd3);
    check("t3_req_cyc", 32'(first_req_cyc), 32'd6);
    check("t3_req_after_drop", 32'(first_req_cyc), 32'(last_drop_cyc + 1));
    check("t3_req_addr", first_req_addr, 32'h100);
    check("t3_seen_deq", 32'(seen_deq), 32'h1);
    check("t3_first_pc", first_deq_pc, 32'h100);

    // Redirect in the same cycle as a dequeue and a response.
    do_reset(1'b0);
    lat = 1;
    for (int c = 0; c < 13; c++) begin
      redirect    = (c == 5);
      redirect_pc = 32'h400;
      obs();
      if (c == 6) begin
        check("t4_valid_low", 32'(inst_valid), 32'h0);
        check("t4_req", 32'(imem_req), 32'h1);
        check("t4_addr", imem_addr, 32'h400);
      end
      adv();
    end
    redirect = 1'b0;
    check("t4_drops", 32'(n_drop), 32'd1);
    check("t4_req_cyc", 32'(first_req_cyc), 32'd6);
    check("t4_first_pc", first_deq_pc, 32'h400);

    // Back-to-back redirects while flushing: the last one wins.
    do_reset(1'b0);
    lat = 3;
    for (int c = 0; c < 16; c++) begin
      redirect    = (c == 3 || c == 4);
      redirect_pc = (c == 3) ? 32'h200 : 32'h300;
      obs();
      if (c == 5) begin
        check("t5_flush_state", 32'(dbg_state), 32'h1);
        check("t5_flush_noreq", 32'(imem_req), 32'h0);
      end
      adv();
    end
    redirect = 1'b0;
    check("t5_drops", 32'(n_drop), 32'd3);
    check("t5_req_cyc", 32'(first_req_cyc), 32'd6);
    check("t5_req_addr", first_req_addr, 32'h300);
    check("t5_first_pc", first_deq_pc, 32'h300);

    // Random grants, stalls and redirects against the scoreboard.
    do_reset(1'b0);
    lat      = 2;
    gnt_rand = 1'b1;
    for (int c = 0; c < 400; c++) begin
      stallF      = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      obs();
      adv();
    end
    check("rand_progress", 32'(n_deq > 20), 32'h1);

    // Reset in the middle of traffic clears everything at the next edge.
    redirect = 1'b0;
    stallF   = 1'b0;
    gnt_rand = 1'b0;
    rst      = 1'b1;
    obs();
    adv();
    rst = 1'b0;
    obs();
    check("mid_rst_valid", 32'(inst_valid), 32'h0);
    check("mid_rst_req", 32'(imem_req), 32'h1);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_pc", pcF, 32'h0);
    check("mid_rst_instr", instrF, 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Prefetching instruction-fetch queue between the instruction SRAM port and the Fetch stage of the 5-stage MIPS pipeline. It issues sequential fetch requests, accepts in-order responses of arbitrary latency, and buffers {pc, instr} pairs. It presents them to the datapath as `instrF`/`pcF` with a valid flag. On a redirect (taken branch prediction, jump, or mispredict recovery) it discards all buffered and in-flight instructions and restarts fetching at the new PC.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk` in 1 — rising-edge clock
- `rst` in 1 — synchronous, active-high reset
- `redirect` in 1 — discard contents and restart at `redirect_pc`
- `redirect_pc` in 32 — restart address, word aligned
- `stallF` in 1 — consumer not accepting this cycle
- `imem_req` out 1 — fetch request valid
- `imem_addr` out 32 — fetch address
- `imem_gnt` in 1 — request accepted when `imem_req & imem_gnt`
- `imem_rvalid` in 1 — response valid; responses return strictly in request order
- `imem_rdata` in 32 — response instruction word
- `inst_valid` out 1 — head entry valid
- `instrF` out 32 — head instruction; 0 when empty
- `pcF` out 32 — head PC; 0 when empty

## Operation
- Storage: circular buffer of DEPTH {pc, instr} entries with rd/wr pointers (log2 DEPTH bits, wrap naturally) and `count` (log2(DEPTH+1) bits).
- `inflight` counter (log2(DEPTH+1) bits): +1 on grant, −1 on `imem_rvalid`, both in the same cycle → unchanged.
- `fetch_pc` register drives `imem_addr`; it advances by 4 on each grant, with 32-bit wrap.
- Credit rule: `imem_req = (state==RUN) & ~redirect & ~rst & (count + inflight < DEPTH)`. The queue therefore can never overflow. A response arriving when full is an assertion failure.
- Response in RUN: `{pc_of_request, imem_rdata}` is written at wr_ptr. The request PC is kept in a DEPTH-deep in-order PC shadow, or is recomputed as `fetch_pc − 4·inflight`; either is allowed.
- Dequeue: `deq = inst_valid & ~stallF & ~redirect`, which advances rd_ptr. Enqueue and dequeue in the same cycle leave `count` unchanged.
- States:
  - RUN: normal operation.
  - FLUSH: drops responses until `inflight` reaches 0, with no requests issued.
- Redirect (any state):
  - Next cycle `count=0` and the pointers are equal. Any response arriving in the redirect cycle is discarded.
  - `fetch_pc <= redirect_pc`.
  - Let `remaining = inflight − imem_rvalid`. If `remaining > 0`, go to FLUSH; otherwise RUN.
- FLUSH → RUN in the cycle after `inflight` reaches 0. A redirect received during FLUSH updates `fetch_pc` and stays in FLUSH; the last redirect wins.

## Timing
- Reset values: `imem_req=0`, `inst_valid=0`, `instrF=0`, `pcF=0`, `imem_addr=RESET_PC`, state RUN, `count=0`, `inflight=0`.
- First `imem_req` is asserted in the first cycle after `rst` deasserts.
- Latency, without bypass: response at cycle t → `inst_valid` at t+1.
- Throughput: one instruction per cycle, sustained when memory returns one response per cycle and `inflight` never reaches DEPTH.
- Redirect at cycle t:
  - `inst_valid=0` at t+1.
  - Request for `redirect_pc` at t+1 if nothing is in flight.
  - Otherwise the request is issued the cycle after the last stale response.
- Reset asserted mid-operation clears everything at the next edge. Responses arriving afterward for pre-reset requests are not tracked; the memory is reset on the same `rst`.

## Configuration
- `IFQ_BYPASS_EN`:
  - Defined: when `count==0`, state is RUN and `imem_rvalid` is high, the response appears combinationally on `instrF`/`pcF` with `inst_valid=1` in the same cycle. If it is dequeued in that cycle, it is not written into the buffer.
  - Undefined: outputs are driven only from buffer registers (latency t+1 as above).

## Test plan
- Reset, then single-cycle memory with `gnt=1`, `stallF=0`: requests at 0x0, 0x4, 0x8…. Responses are word-aligned. `pcF` advances 0x0, 0x4, 0x8… one per cycle from the second post-reset response cycle onward.
- Hold `stallF=1` for 10 cycles with DEPTH=4: `imem_req` drops once `count+inflight=4`. The queue holds 0x0–0xC with no loss. After release, 4 consecutive dequeues in order.
- 3-cycle memory latency with 3 in flight, `redirect=1` with `redirect_pc=0x100`:
  - FLUSH lasts until 3 responses have been dropped.
  - First new request is 0x100.
  - No stale PC ever appears on `pcF`.
- Redirect coinciding with a dequeue and a response: neither instruction is consumed or buffered, and `inst_valid=0` next cycle.
- Back-to-back redirects (0x200 then 0x300) during FLUSH: the fetch resumes at 0x300 only.
- With `IFQ_BYPASS_EN`: empty queue, response 0x2402_0001 at cycle t → `instrF=0x2402_0001` and `inst_valid=1` in cycle t. Without the macro → at t+1.
